// File: rtl/offside_call_monitor.sv
// Qualifies the detector's offside indication P over HOLD_CYCLES consecutive
// samples, latches a call until acknowledged, and counts confirmed calls.
module offside_call_monitor #(
  parameter int HOLD_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             P,
  input  logic             ACK,
  output logic             FLAG,
  output logic [CNT_W-1:0] CALL_CNT,
  output logic [1:0]       STATE
);

  localparam int RUN_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [RUN_W-1:0] HOLD_L  = RUN_W'(HOLD_CYCLES);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_FLAG     = 2'd2,
    S_WAIT_LOW = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             call_inc;

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    call_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (P) begin
          run_d = RUN_ONE;
          if (HOLD_CYCLES == 1) begin
            state_d  = S_FLAG;
            call_inc = 1'b1;
          end else begin
            state_d = S_ARMED;
          end
        end else begin
          run_d = '0;
        end
      end
      S_ARMED: begin
        if (!P) begin
          state_d = S_IDLE;
          run_d   = '0;
        end else begin
          run_d = run_q + RUN_ONE;
          if (run_q + RUN_ONE == HOLD_L) begin
            state_d  = S_FLAG;
            call_inc = 1'b1;
          end
        end
      end
      S_FLAG: begin
        // Holding P high through the ACK must not re-arm: park in WAIT_LOW.
        if (ACK) begin
          state_d = P ? S_WAIT_LOW : S_IDLE;
          run_d   = '0;
        end
      end
      S_WAIT_LOW: begin
        run_d = '0;
        if (!P) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        run_d   = '0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (call_inc && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      run_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
    end
  end

  assign FLAG     = (state_q == S_FLAG);
  assign CALL_CNT = cnt_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_offside_call_monitor.sv
// Table-driven scoreboard bench for offside_call_monitor across three builds:
// (HOLD 3, CNT 8), (HOLD 3, CNT 2) and (HOLD 1, CNT 8).
module tb_offside_call_monitor;

  typedef struct {
    logic [1:0] sel;
    logic       rst;
    logic       p;
    logic       ack;
    logic       flag;
    logic [7:0] cnt;
    logic [1:0] st;
  } vec_t;

  logic CLK = 1'b0;
  logic rst_v = 1'b1;
  logic P = 1'b0;
  logic ACK = 1'b0;
  logic [1:0] cur_sel = 2'd0;

  logic rst0, rst1, rst2;
  logic flag0, flag1, flag2;
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;
  logic [1:0] st0, st1, st2;

  int checks = 0;
  int errors = 0;
  int vec_no = 0;

  vec_t tbl[$];
  vec_t sb[$];

  always #5 CLK = ~CLK;

  // Builds not under test are held in reset.
  assign rst0 = (cur_sel == 2'd0) ? rst_v : 1'b1;
  assign rst1 = (cur_sel == 2'd1) ? rst_v : 1'b1;
  assign rst2 = (cur_sel == 2'd2) ? rst_v : 1'b1;

  offside_call_monitor #(.HOLD_CYCLES(3), .CNT_W(8)) u_h3c8 (
    .CLK(CLK), .RST(rst0), .P(P), .ACK(ACK),
    .FLAG(flag0), .CALL_CNT(cnt0), .STATE(st0));

  offside_call_monitor #(.HOLD_CYCLES(3), .CNT_W(2)) u_h3c2 (
    .CLK(CLK), .RST(rst1), .P(P), .ACK(ACK),
    .FLAG(flag1), .CALL_CNT(cnt1), .STATE(st1));

  offside_call_monitor #(.HOLD_CYCLES(1), .CNT_W(8)) u_h1c8 (
    .CLK(CLK), .RST(rst2), .P(P), .ACK(ACK),
    .FLAG(flag2), .CALL_CNT(cnt2), .STATE(st2));

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Expected values land in the queue with the stimulus; the entry at the head
  // describes outputs after the most recent rising edge.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      vec_t v;
      logic f;
      logic [7:0] c;
      logic [1:0] s;
      v = sb.pop_front();
      case (v.sel)
        2'd0:    begin f = flag0; c = cnt0;         s = st0; end
        2'd1:    begin f = flag1; c = {6'd0, cnt1}; s = st1; end
        default: begin f = flag2; c = cnt2;         s = st2; end
      endcase
      check("flag",  vec_no, int'(f), int'(v.flag));
      check("cnt",   vec_no, int'(c), int'(v.cnt));
      check("state", vec_no, int'(s), int'(v.st));
      vec_no++;
    end
  end

  task automatic drive(input vec_t v);
    cur_sel = v.sel;
    rst_v   = v.rst;
    P       = v.p;
    ACK     = v.ack;
    sb.push_back(v);
    @(posedge CLK);
    #2;
  endtask

  task automatic add(input logic [1:0] sel, input logic rst, input logic p, input logic ack,
                     input logic flag, input logic [7:0] cnt, input logic [1:0] st);
    vec_t v;
    v.sel = sel; v.rst = rst; v.p = p; v.ack = ack;
    v.flag = flag; v.cnt = cnt; v.st = st;
    tbl.push_back(v);
  endtask

  initial begin
    // ---- HOLD 3 / CNT 8 ----
    // reset with P and ACK high
    add(0, 1, 1, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    // glitches (ACK high in IDLE/ARMED is ignored)
    add(0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    // qualification: 3 high samples, then ACK with P low
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 1, 1, 2);
    add(0, 0, 0, 0, 1, 1, 2);
    add(0, 0, 1, 0, 1, 1, 2);
    add(0, 0, 0, 1, 0, 1, 0);
    // reset mid-qualification
    add(0, 0, 1, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 1, 1);
    add(0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    foreach (tbl[i]) drive(tbl[i]);

    // held condition: P high 20 edges, ACK on edge 8
    for (int e = 1; e <= 20; e++) begin
      vec_t v;
      v.sel = 0; v.rst = 0; v.p = 1; v.ack = (e == 8);
      v.cnt = 1;
      if (e < 3)       begin v.st = 1; v.flag = 0; v.cnt = 0; end
      else if (e < 8)  begin v.st = 2; v.flag = 1; end
      else             begin v.st = 3; v.flag = 0; end
      drive(v);
    end
    drive('{sel: 0, rst: 0, p: 0, ack: 1, flag: 0, cnt: 1, st: 0});
    drive('{sel: 0, rst: 0, p: 1, ack: 0, flag: 0, cnt: 1, st: 1});
    drive('{sel: 0, rst: 0, p: 1, ack: 0, flag: 0, cnt: 1, st: 1});
    drive('{sel: 0, rst: 0, p: 1, ack: 0, flag: 1, cnt: 2, st: 2});
    drive('{sel: 0, rst: 0, p: 1, ack: 0, flag: 1, cnt: 2, st: 2});
    // reset while a call is pending
    drive('{sel: 0, rst: 1, p: 1, ack: 0, flag: 0, cnt: 0, st: 0});

    // ---- HOLD 3 / CNT 2: saturation ----
    drive('{sel: 1, rst: 1, p: 0, ack: 0, flag: 0, cnt: 0, st: 0});
    for (int k = 1; k <= 5; k++) begin
      logic [7:0] prev, now;
      prev = (k - 1 < 3) ? 8'(k - 1) : 8'd3;
      now  = (k < 3) ? 8'(k) : 8'd3;
      drive('{sel: 1, rst: 0, p: 1, ack: 0, flag: 0, cnt: prev, st: 1});
      drive('{sel: 1, rst: 0, p: 1, ack: 0, flag: 0, cnt: prev, st: 1});
      drive('{sel: 1, rst: 0, p: 1, ack: 0, flag: 1, cnt: now,  st: 2});
      drive('{sel: 1, rst: 0, p: 0, ack: 1, flag: 0, cnt: now,  st: 0});
    end

    // ---- HOLD 1 / CNT 8 ----
    drive('{sel: 2, rst: 1, p: 1, ack: 0, flag: 0, cnt: 0, st: 0});
    drive('{sel: 2, rst: 0, p: 1, ack: 0, flag: 1, cnt: 1, st: 2});
    drive('{sel: 2, rst: 0, p: 1, ack: 1, flag: 0, cnt: 1, st: 3});
    drive('{sel: 2, rst: 0, p: 1, ack: 1, flag: 0, cnt: 1, st: 3});
    drive('{sel: 2, rst: 0, p: 0, ack: 0, flag: 0, cnt: 1, st: 0});
    drive('{sel: 2, rst: 0, p: 1, ack: 0, flag: 1, cnt: 2, st: 2});
    drive('{sel: 2, rst: 0, p: 0, ack: 1, flag: 0, cnt: 2, st: 0});

    @(negedge CLK);
    #1;
    check("sb_drain", vec_no, sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
